uart_rx: RTL and testbench

UART receive path: recovers 8N1 serial frames from the RX line and presents each byte in parallel. It is the receiving counterpart of the transmit PISO shifter. The line idles high and carries data LSB first. Internally it has an input synchronizer, a bit-period counter, a receive FSM and a shift-in register. Each good frame produces `RX_data` with a one-cycle `RX_valid` pulse. A bad stop bit produces a one-cycle `framing_err` pulse instead.

---
 rtl/uart_rx.sv | 172 +++++++++++++++++
 tb/tb_uart_rx.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver.
//   Recovers LSB-first serial frames from an idle-high line and presents each
//   good byte in parallel with a one-cycle valid strobe. A low stop bit raises
//   a one-cycle framing error instead, and the receiver then waits for the
//   line to return high before hunting for the next start bit.
//
// Ports:
//   CLK          clock, all logic on the rising edge
//   RST          asynchronous active-high reset
//   RX_in        serial line, asynchronous to CLK, idle high
//   RX_data[7:0] last correctly received byte, held until the next good frame
//   RX_valid     one-cycle pulse, RX_data updated this cycle
//   framing_err  one-cycle pulse, stop bit sampled low
//   busy         high whenever the receiver is not idle
//
// CLKS_PER_BIT must be even and at least 4.
module uart_rx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RX_in,
  output logic [7:0] RX_data,
  output logic       RX_valid,
  output logic       framing_err,
  output logic       busy
);

  localparam int unsigned N     = CLKS_PER_BIT;
  localparam int unsigned HALF  = N / 2;
  localparam int unsigned CNT_W = $clog2(N);

  localparam logic [CNT_W-1:0] HALF_END = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(N - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  state_t           r_state;
  state_t           w_state_nx;

  logic             r_sync1;
  logic             r_sync2;
  logic             w_rx_s;

  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_idx;
  logic [7:0]       r_sr;
  logic [7:0]       r_data;
  logic             r_valid;
  logic             r_err;

  logic             w_half_end;
  logic             w_bit_end;
  logic             w_busy;
  logic             w_cnt_run;
  logic             w_cnt_clr;
  logic             w_shift;
  logic             w_stop_ok;
  logic             w_stop_bad;

  // Two-flop synchronizer; both stages reset to the idle level so that
  // reset release never looks like a start bit.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= RX_in;
      r_sync2 <= r_sync1;
    end
  end

  assign w_rx_s = r_sync2;

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE: begin
        if (!w_rx_s) w_state_nx = S_START;
      end
      S_START: begin
        // Half a bit in: a line that is high again was only a glitch.
        if (w_half_end) w_state_nx = w_rx_s ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (w_bit_end && (r_idx == 3'd7)) w_state_nx = S_STOP;
      end
      S_STOP: begin
        if (w_bit_end) w_state_nx = w_rx_s ? S_IDLE : S_WAIT_HIGH;
      end
      S_WAIT_HIGH: begin
        if (w_rx_s) w_state_nx = S_IDLE;
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  // Output / control decode
  always_comb begin
    w_half_end = (r_cnt == HALF_END);
    w_bit_end  = (r_cnt == BIT_END);
    w_busy     = (r_state != S_IDLE);
    w_cnt_run  = (r_state == S_START) || (r_state == S_DATA) || (r_state == S_STOP);
    w_cnt_clr  = ((r_state == S_START) && w_half_end) ||
                 (((r_state == S_DATA) || (r_state == S_STOP)) && w_bit_end);
    w_shift    = (r_state == S_DATA) && w_bit_end;
    w_stop_ok  = (r_state == S_STOP) && w_bit_end && w_rx_s;
    w_stop_bad = (r_state == S_STOP) && w_bit_end && !w_rx_s;
  end

  // Datapath: bit-period counter, bit index, shift-in register, outputs
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_cnt   <= '0;
      r_idx   <= '0;
      r_sr    <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_err   <= 1'b0;

      if (w_cnt_clr || !w_cnt_run) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end

      if (r_state == S_IDLE) begin
        r_idx <= '0;
      end else if (w_shift) begin
        r_idx <= r_idx + 3'd1;
      end

      if (w_shift) begin
        r_sr <= {w_rx_s, r_sr[7:1]};
      end

      if (w_stop_ok) begin
        r_data  <= r_sr;
        r_valid <= 1'b1;
      end

      if (w_stop_bad) begin
        r_err <= 1'b1;
      end
    end
  end

  assign RX_data     = r_data;
  assign RX_valid    = r_valid;
  assign framing_err = r_err;
  assign busy        = w_busy;

endmodule

// File: tb/tb_uart_rx.sv
// Directed testbench for uart_rx. Three receivers share clock and reset:
// index 0 runs at 16 clocks/bit, index 1 at 4, index 2 at 868. Edge numbers
// count rising clock edges from the first one (edge 1); t0 is the first edge
// that samples the start bit low.
module tb_uart_rx;

  logic       CLK;
  logic       RST;
  logic       rx_line [3];
  logic [7:0] rx_data [3];
  logic       rx_valid[3];
  logic       rx_err  [3];
  logic       rx_busy [3];

  int total = 0;
  int bad   = 0;
  int edges = 0;

  // Pulse / busy observations, updated on every falling edge.
  int         v_cnt      [3] = '{default: 0};
  int         v_edge     [3] = '{default: -1};
  logic [7:0] v_data     [3] = '{default: 8'h00};
  int         v_prev_edge[3] = '{default: -1};
  logic [7:0] v_prev_data[3] = '{default: 8'h00};
  int         e_cnt      [3] = '{default: 0};
  int         e_edge     [3] = '{default: -1};
  int         b_rise     [3] = '{default: -1};
  int         b_fall     [3] = '{default: -1};
  logic       b_last     [3] = '{default: 1'b0};
  int         both_cnt = 0;

  uart_rx #(.CLKS_PER_BIT(16)) dut16 (
    .CLK(CLK), .RST(RST), .RX_in(rx_line[0]), .RX_data(rx_data[0]),
    .RX_valid(rx_valid[0]), .framing_err(rx_err[0]), .busy(rx_busy[0])
  );

  uart_rx #(.CLKS_PER_BIT(4)) dut4 (
    .CLK(CLK), .RST(RST), .RX_in(rx_line[1]), .RX_data(rx_data[1]),
    .RX_valid(rx_valid[1]), .framing_err(rx_err[1]), .busy(rx_busy[1])
  );

  uart_rx #(.CLKS_PER_BIT(868)) dut868 (
    .CLK(CLK), .RST(RST), .RX_in(rx_line[2]), .RX_data(rx_data[2]),
    .RX_valid(rx_valid[2]), .framing_err(rx_err[2]), .busy(rx_busy[2])
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  always @(posedge CLK) edges <= edges + 1;

  always @(negedge CLK) begin
    for (int i = 0; i < 3; i++) begin
      if (rx_valid[i]) begin
        v_cnt[i]       = v_cnt[i] + 1;
        v_prev_edge[i] = v_edge[i];
        v_prev_data[i] = v_data[i];
        v_edge[i]      = edges;
        v_data[i]      = rx_data[i];
      end
      if (rx_err[i]) begin
        e_cnt[i]  = e_cnt[i] + 1;
        e_edge[i] = edges;
      end
      if (rx_valid[i] && rx_err[i]) both_cnt = both_cnt + 1;
      if (rx_busy[i] && !b_last[i]) b_rise[i] = edges;
      if (!rx_busy[i] && b_last[i]) b_fall[i] = edges;
      b_last[i] = rx_busy[i];
    end
  end

  // Called just after a falling edge; returns just after a falling edge.
  // Leaves the line at the stop-bit level.
  task automatic send_frame(input int which, input int n, input logic [7:0] b,
                            input logic stop, output int t0);
    rx_line[which] = 1'b0;
    t0 = edges + 1;
    repeat (n) @(negedge CLK);
    for (int k = 0; k < 8; k++) begin
      rx_line[which] = b[k];
      repeat (n) @(negedge CLK);
    end
    rx_line[which] = stop;
    repeat (n) @(negedge CLK);
  endtask

  task automatic test_reset;
    @(negedge CLK);
    for (int i = 0; i < 3; i++) begin
      total++; if (rx_data[i] !== 8'h00) begin bad++; $display("FAIL reset_data[%0d]: got %h want 00", i, rx_data[i]); end
      total++; if (rx_valid[i] !== 1'b0) begin bad++; $display("FAIL reset_valid[%0d]: got %b want 0", i, rx_valid[i]); end
      total++; if (rx_err[i] !== 1'b0) begin bad++; $display("FAIL reset_err[%0d]: got %b want 0", i, rx_err[i]); end
      total++; if (rx_busy[i] !== 1'b0) begin bad++; $display("FAIL reset_busy[%0d]: got %b want 0", i, rx_busy[i]); end
    end
    RST = 1'b0;
    repeat (5) @(negedge CLK);
    total++; if (rx_busy[0] !== 1'b0) begin bad++; $display("FAIL idle_busy: got %b want 0", rx_busy[0]); end
  endtask

  task automatic test_single_byte;
    int t0, vc, ec;
    vc = v_cnt[0]; ec = e_cnt[0];
    send_frame(0, 16, 8'hA5, 1'b1, t0);
    repeat (10) @(negedge CLK);
    total++; if (v_cnt[0] - vc !== 1) begin bad++; $display("FAIL single_vcount: got %0d want 1", v_cnt[0] - vc); end
    total++; if (v_edge[0] !== t0 + 154) begin bad++; $display("FAIL single_vedge: got %0d want %0d", v_edge[0], t0 + 154); end
    total++; if (v_data[0] !== 8'hA5) begin bad++; $display("FAIL single_data: got %h want a5", v_data[0]); end
    total++; if (rx_data[0] !== 8'hA5) begin bad++; $display("FAIL single_hold: got %h want a5", rx_data[0]); end
    total++; if (e_cnt[0] - ec !== 0) begin bad++; $display("FAIL single_err: got %0d want 0", e_cnt[0] - ec); end
    total++; if (b_rise[0] !== t0 + 2) begin bad++; $display("FAIL single_busy_rise: got %0d want %0d", b_rise[0], t0 + 2); end
    total++; if (b_fall[0] !== t0 + 154) begin bad++; $display("FAIL single_busy_fall: got %0d want %0d", b_fall[0], t0 + 154); end
  endtask

  task automatic test_glitch;
    int t0, vc, ec;
    vc = v_cnt[0]; ec = e_cnt[0];
    rx_line[0] = 1'b0;
    t0 = edges + 1;
    repeat (3) @(negedge CLK);
    rx_line[0] = 1'b1;
    repeat (30) @(negedge CLK);
    total++; if (b_rise[0] !== t0 + 2) begin bad++; $display("FAIL glitch_busy_rise: got %0d want %0d", b_rise[0], t0 + 2); end
    total++; if (b_fall[0] !== t0 + 10) begin bad++; $display("FAIL glitch_busy_fall: got %0d want %0d", b_fall[0], t0 + 10); end
    total++; if (v_cnt[0] - vc !== 0) begin bad++; $display("FAIL glitch_valid: got %0d want 0", v_cnt[0] - vc); end
    total++; if (e_cnt[0] - ec !== 0) begin bad++; $display("FAIL glitch_err: got %0d want 0", e_cnt[0] - ec); end
    total++; if (rx_data[0] !== 8'hA5) begin bad++; $display("FAIL glitch_data: got %h want a5", rx_data[0]); end
  endtask

  task automatic test_framing;
    int t0, t1, vc, ec;
    vc = v_cnt[0]; ec = e_cnt[0];
    send_frame(0, 16, 8'h3C, 1'b0, t0);
    repeat (40) @(negedge CLK);
    total++; if (rx_busy[0] !== 1'b1) begin bad++; $display("FAIL frame_wait_busy: got %b want 1", rx_busy[0]); end
    rx_line[0] = 1'b1;
    repeat (10) @(negedge CLK);
    total++; if (e_cnt[0] - ec !== 1) begin bad++; $display("FAIL frame_err_count: got %0d want 1", e_cnt[0] - ec); end
    total++; if (e_edge[0] !== t0 + 154) begin bad++; $display("FAIL frame_err_edge: got %0d want %0d", e_edge[0], t0 + 154); end
    total++; if (v_cnt[0] - vc !== 0) begin bad++; $display("FAIL frame_valid: got %0d want 0", v_cnt[0] - vc); end
    total++; if (rx_data[0] !== 8'hA5) begin bad++; $display("FAIL frame_data_kept: got %h want a5", rx_data[0]); end
    total++; if (b_fall[0] !== t0 + 202) begin bad++; $display("FAIL frame_busy_fall: got %0d want %0d", b_fall[0], t0 + 202); end
    vc = v_cnt[0]; ec = e_cnt[0];
    send_frame(0, 16, 8'h5A, 1'b1, t1);
    repeat (10) @(negedge CLK);
    total++; if (v_cnt[0] - vc !== 1) begin bad++; $display("FAIL after_frame_vcount: got %0d want 1", v_cnt[0] - vc); end
    total++; if (v_edge[0] !== t1 + 154) begin bad++; $display("FAIL after_frame_vedge: got %0d want %0d", v_edge[0], t1 + 154); end
    total++; if (rx_data[0] !== 8'h5A) begin bad++; $display("FAIL after_frame_data: got %h want 5a", rx_data[0]); end
    total++; if (e_cnt[0] - ec !== 0) begin bad++; $display("FAIL after_frame_err: got %0d want 0", e_cnt[0] - ec); end
  endtask

  task automatic test_back_to_back;
    int ta, tb, vc, ec;
    vc = v_cnt[0]; ec = e_cnt[0];
    send_frame(0, 16, 8'h00, 1'b1, ta);
    send_frame(0, 16, 8'hFF, 1'b1, tb);
    repeat (10) @(negedge CLK);
    total++; if (v_cnt[0] - vc !== 2) begin bad++; $display("FAIL b2b_vcount: got %0d want 2", v_cnt[0] - vc); end
    total++; if (v_prev_edge[0] !== ta + 154) begin bad++; $display("FAIL b2b_first_edge: got %0d want %0d", v_prev_edge[0], ta + 154); end
    total++; if (v_edge[0] - v_prev_edge[0] !== 160) begin bad++; $display("FAIL b2b_spacing: got %0d want 160", v_edge[0] - v_prev_edge[0]); end
    total++; if (v_prev_data[0] !== 8'h00) begin bad++; $display("FAIL b2b_first_data: got %h want 00", v_prev_data[0]); end
    total++; if (v_data[0] !== 8'hFF) begin bad++; $display("FAIL b2b_second_data: got %h want ff", v_data[0]); end
    total++; if (e_cnt[0] - ec !== 0) begin bad++; $display("FAIL b2b_err: got %0d want 0", e_cnt[0] - ec); end
    total++; if (both_cnt !== 0) begin bad++; $display("FAIL valid_and_err_together: got %0d want 0", both_cnt); end
  endtask

  task automatic test_reset_mid_frame;
    int ta, t1, vc, ec;
    vc = v_cnt[0]; ec = e_cnt[0];
    fork
      send_frame(0, 16, 8'h81, 1'b1, ta);
      begin
        repeat (85) @(negedge CLK);   // inside data bit 4
        RST = 1'b1;
        #1;
        total++; if (rx_data[0] !== 8'h00) begin bad++; $display("FAIL midrst_data: got %h want 00", rx_data[0]); end
        total++; if (rx_busy[0] !== 1'b0) begin bad++; $display("FAIL midrst_busy: got %b want 0", rx_busy[0]); end
        total++; if (rx_valid[0] !== 1'b0) begin bad++; $display("FAIL midrst_valid: got %b want 0", rx_valid[0]); end
      end
    join
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    repeat (5) @(negedge CLK);
    total++; if (v_cnt[0] - vc !== 0) begin bad++; $display("FAIL midrst_no_pulse: got %0d want 0", v_cnt[0] - vc); end
    total++; if (e_cnt[0] - ec !== 0) begin bad++; $display("FAIL midrst_no_err: got %0d want 0", e_cnt[0] - ec); end
    send_frame(0, 16, 8'h81, 1'b1, t1);
    repeat (10) @(negedge CLK);
    total++; if (v_cnt[0] - vc !== 1) begin bad++; $display("FAIL midrst_next_vcount: got %0d want 1", v_cnt[0] - vc); end
    total++; if (v_edge[0] !== t1 + 154) begin bad++; $display("FAIL midrst_next_edge: got %0d want %0d", v_edge[0], t1 + 154); end
    total++; if (rx_data[0] !== 8'h81) begin bad++; $display("FAIL midrst_next_data: got %h want 81", rx_data[0]); end
  endtask

  task automatic test_sweep;
    int t0, vc, ec;
    // N=4: HALF=2, valid at t0+2+2+36
    vc = v_cnt[1]; ec = e_cnt[1];
    send_frame(1, 4, 8'hA5, 1'b1, t0);
    repeat (10) @(negedge CLK);
    total++; if (v_cnt[1] - vc !== 1) begin bad++; $display("FAIL n4_vcount: got %0d want 1", v_cnt[1] - vc); end
    total++; if (v_edge[1] !== t0 + 40) begin bad++; $display("FAIL n4_vedge: got %0d want %0d", v_edge[1], t0 + 40); end
    total++; if (rx_data[1] !== 8'hA5) begin bad++; $display("FAIL n4_data: got %h want a5", rx_data[1]); end
    total++; if (e_cnt[1] - ec !== 0) begin bad++; $display("FAIL n4_err: got %0d want 0", e_cnt[1] - ec); end
    // N=868: HALF=434, valid at t0+2+434+7812
    vc = v_cnt[2]; ec = e_cnt[2];
    send_frame(2, 868, 8'h6B, 1'b1, t0);
    repeat (20) @(negedge CLK);
    total++; if (v_cnt[2] - vc !== 1) begin bad++; $display("FAIL n868_vcount: got %0d want 1", v_cnt[2] - vc); end
    total++; if (v_edge[2] !== t0 + 8248) begin bad++; $display("FAIL n868_vedge: got %0d want %0d", v_edge[2], t0 + 8248); end
    total++; if (rx_data[2] !== 8'h6B) begin bad++; $display("FAIL n868_data: got %h want 6b", rx_data[2]); end
    total++; if (b_rise[2] !== t0 + 2) begin bad++; $display("FAIL n868_busy_rise: got %0d want %0d", b_rise[2], t0 + 2); end
    total++; if (e_cnt[2] - ec !== 0) begin bad++; $display("FAIL n868_err: got %0d want 0", e_cnt[2] - ec); end
  endtask

  initial begin
    RST = 1'b1;
    for (int i = 0; i < 3; i++) rx_line[i] = 1'b1;
    test_reset;
    test_single_byte;
    test_glitch;
    test_framing;
    test_back_to_back;
    test_reset_mid_frame;
    test_sweep;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
